// File: rtl/uniform_reject_sampler.sv
// Rejection sampler: splits 64-bit PRNG words into COEFF_W-bit chunks, keeps
// those below Q, and streams them out through a small FIFO until N_COEFFS are produced.
module uniform_reject_sampler #(
  parameter int                 COEFF_W    = 30,
  parameter logic [COEFF_W-1:0] Q          = 30'd1073479681,
  parameter int                 N_COEFFS   = 4096,
  parameter int                 FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [63:0]        random_in,
  input  logic               random_valid,
  output logic               random_ready,
  output logic [COEFF_W-1:0] coeff_out,
  output logic               coeff_valid,
  input  logic               coeff_ready,
  output logic               busy,
  output logic               done
);
  localparam int K  = 64 / COEFF_W;
  localparam int KW = K * COEFF_W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int CW = $clog2(N_COEFFS + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_COEFFS - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SPLIT, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [KW-1:0]               word;
  logic [K-1:0][COEFF_W-1:0]   chunks;
  logic [IW-1:0]               idx;
  logic [CW-1:0]               cnt;
  logic [COEFF_W-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 fill;
  logic full, empty, accept, take, pop, push, advance, last_push;

  // Bits above K*COEFF_W never reach the datapath.
  generate
    if (KW < 64) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^random_in[63:KW];
    end
  endgenerate

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign chunks    = word;
  assign accept    = chunks[idx] < Q;
  assign full      = (fill == DEPTH);
  assign empty     = (fill == '0);
  assign take      = random_valid & random_ready;
  assign pop       = coeff_valid & coeff_ready;
  assign last_push = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  if (take)  state_nxt = SPLIT;
      SPLIT: begin
        if (push && last_push)               state_nxt = DRAIN;
        else if (advance && idx == IDX_LAST) state_nxt = LOAD;
      end
      DRAIN: if (empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rejected chunks advance even when full; only accepted ones wait for space.
  always_comb begin
    random_ready = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    push         = 1'b0;
    advance      = 1'b0;
    case (state)
      IDLE:  busy = 1'b0;
      LOAD:  random_ready = 1'b1;
      SPLIT: begin
        push    = accept & ~full;
        advance = ~accept | ~full;
      end
      DRAIN: done = empty;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else begin
      if (state == IDLE && start) begin
        cnt <= '0;
        idx <= '0;
      end
      if (take) word <= random_in[KW-1:0];
      if (push) cnt  <= cnt + 1'b1;
      if (advance) idx <= (idx == IDX_LAST || (push && last_push)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= chunks[idx];
  end

  // Storage is not reset, so the head is masked while empty.
  assign coeff_valid = ~empty;
  assign coeff_out   = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uniform_reject_sampler.sv
// Bench for uniform_reject_sampler: directed accept/reject/backpressure/run-end/reset
// cases plus randomized runs scored against a queue-based model of the sampling rule.
module tb_uniform_reject_sampler;
  localparam int          N  = 9;
  localparam logic [29:0] QV = 30'd1073479681;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        random_valid = 1'b0, coeff_ready = 1'b0;
  logic [63:0] random_in = '0;
  logic        random_ready, coeff_valid, busy, done;
  logic [29:0] coeff_out;

  int n_vec = 0, n_err = 0, done_cnt = 0, words_taken = 0, exp_words = 0;
  logic [29:0] got_q[$];
  logic [29:0] exp_q[$];
  logic [63:0] words_q[$];

  always #5 clk = ~clk;

  uniform_reject_sampler #(.COEFF_W(30), .Q(QV), .N_COEFFS(N), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .random_in(random_in), .random_valid(random_valid), .random_ready(random_ready),
    .coeff_out(coeff_out), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observes the handshakes that the coming posedge will perform.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (coeff_valid && coeff_ready) got_q.push_back(coeff_out);
      if (random_valid && random_ready) words_taken++;
      if (done) done_cnt++;
    end
  end

  function automatic logic [63:0] mk(input logic [29:0] a, input logic [29:0] b);
    return {4'h0, b, a};
  endfunction

  function automatic logic [29:0] rnd_chunk();
    case ($urandom_range(0, 5))
      0:       return QV + 30'($urandom_range(0, 262142));
      1:       return QV;
      2:       return QV - 30'd1;
      3:       return 30'h3FFF_FFFF;
      default: return 30'($urandom_range(0, 1073479680));
    endcase
  endfunction

  // Model: chunks LSB-first, keep those below Q, stop at the N-th keep.
  task automatic build_expect();
    logic [63:0] c;
    exp_q.delete();
    exp_words = 0;
    for (int i = 0; i < words_q.size() && exp_q.size() < N; i++) begin
      exp_words++;
      for (int k = 0; k < 2; k++) begin
        c = (words_q[i] >> (30 * k)) & 64'h3FFF_FFFF;
        if (c < 64'(QV) && exp_q.size() < N) exp_q.push_back(c[29:0]);
      end
    end
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; random_valid = 1'b0; coeff_ready = 1'b0;
    #1;
    chk("rst_rready", random_ready, 1'b0);
    chk("rst_cvalid", coeff_valid, 1'b0);
    chk("rst_cout",   coeff_out, 30'd0);
    chk("rst_busy",   busy, 1'b0);
    chk("rst_done",   done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete(); done_cnt = 0; words_taken = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_word(input logic [63:0] w);
    int t = 0;
    random_in = w; random_valid = 1'b1;
    #1;
    while (!random_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    chk("feed_hs", random_ready, 1'b1);
    @(negedge clk);
    random_valid = 1'b0;
  endtask

  task automatic wait_size(input int n);
    int t = 0;
    while (got_q.size() < n && t < 100) begin
      @(negedge clk); t++;
    end
    chk("wait_size", 64'(got_q.size() >= n), 64'd1);
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 200) begin
      @(negedge clk); t++;
    end
    chk("wait_done", 64'(done_cnt > 0), 64'd1);
  endtask

  task automatic random_run();
    int acc, wi, cyc;
    logic [29:0] a, b;
    words_q.delete();
    acc = 0;
    while (acc < N) begin
      a = rnd_chunk(); b = rnd_chunk();
      words_q.push_back({4'($urandom), b, a});
      acc += int'(a < QV) + int'(b < QV);
    end
    words_q.push_back({$urandom, $urandom});
    build_expect();
    do_reset();
    do_start();
    wi = 0; cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      coeff_ready  = ($urandom_range(0, 2) != 0);
      random_valid = (wi < words_q.size()) && ($urandom_range(0, 3) != 0);
      random_in    = random_valid ? words_q[wi] : {$urandom, $urandom};
      start        = ($urandom_range(0, 9) == 0);
      #1;
      if (random_valid && random_ready) wi++;
      @(negedge clk); cyc++;
    end
    start = 1'b0; random_valid = 1'b0; coeff_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("rnd_done",  64'(done_cnt), 64'd1);
    chk("rnd_busy",  busy, 1'b0);
    chk("rnd_empty", coeff_valid, 1'b0);
    chk("rnd_words", 64'(words_taken), 64'(exp_words));
    chk_seq("rnd_coeff");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Accept both chunks, two-cycle latency, no stall.
    do_reset();
    coeff_ready = 1'b1;
    do_start();
    chk("load_rready", random_ready, 1'b1);
    chk("load_busy", busy, 1'b1);
    random_in = 64'h0000_0005_0000_0003; random_valid = 1'b1;
    @(negedge clk); random_valid = 1'b0;
    chk("split_rready", random_ready, 1'b0);
    chk("lat1_cvalid", coeff_valid, 1'b0);
    @(negedge clk);
    chk("lat2_cvalid", coeff_valid, 1'b1);
    chk("lat2_cout", coeff_out, 30'd3);
    @(negedge clk);
    chk("acc_cout1", coeff_out, 30'd20);
    chk("acc_reload", random_ready, 1'b1);
    @(negedge clk);
    chk("acc_empty", coeff_valid, 1'b0);
    chk("acc_words", 64'(words_taken), 64'd1);
    exp_q = '{30'd3, 30'd20};
    chk_seq("acc_seq");

    // Reject chunk 0, keep chunk 1.
    do_reset();
    coeff_ready = 1'b1;
    do_start();
    random_in = 64'h0000_0000_3FFF_FFFF; random_valid = 1'b1;
    @(negedge clk); random_valid = 1'b0;
    @(negedge clk);
    chk("rej_cvalid0", coeff_valid, 1'b0);
    @(negedge clk);
    chk("rej_cvalid1", coeff_valid, 1'b1);
    chk("rej_cout", coeff_out, 30'd0);
    repeat (4) @(negedge clk);
    chk("rej_rready", random_ready, 1'b1);
    exp_q = '{30'd0};
    chk_seq("rej_seq");

    // Backpressure: four pushes fill the FIFO, fifth chunk stalls.
    do_reset();
    do_start();
    feed_word(mk(30'd1, 30'd2));
    feed_word(mk(30'd3, 30'd4));
    feed_word(mk(30'd5, 30'd6));
    repeat (5) @(negedge clk);
    chk("bp_rready", random_ready, 1'b0);
    chk("bp_cvalid", coeff_valid, 1'b1);
    chk("bp_cout", coeff_out, 30'd1);
    chk("bp_busy", busy, 1'b1);
    coeff_ready = 1'b1;
    wait_size(6);
    repeat (3) @(negedge clk);
    chk("bp_words", 64'(words_taken), 64'd3);
    exp_q = '{30'd1, 30'd2, 30'd3, 30'd4, 30'd5, 30'd6};
    chk_seq("bp_seq");

    // Run end with stray start pulses; 10 must be discarded.
    do_reset();
    coeff_ready = 1'b1;
    do_start();
    feed_word(mk(30'd1, 30'd2));
    do_start();
    feed_word(mk(30'd3, 30'd4));
    feed_word(mk(30'd5, 30'd6));
    do_start();
    feed_word(mk(30'd7, 30'd8));
    feed_word(mk(30'd9, 30'd10));
    wait_done();
    repeat (2) @(negedge clk);
    chk("end_done", 64'(done_cnt), 64'd1);
    chk("end_busy", busy, 1'b0);
    chk("end_rready", random_ready, 1'b0);
    chk("end_words", 64'(words_taken), 64'd5);
    exp_q = '{30'd1, 30'd2, 30'd3, 30'd4, 30'd5, 30'd6, 30'd7, 30'd8, 30'd9};
    chk_seq("end_seq");

    // Reset mid-SPLIT with two entries queued, then a clean run restart.
    do_reset();
    do_start();
    feed_word(mk(30'd1, 30'd2));
    feed_word(mk(30'd3, 30'd4));
    chk("mid_cvalid", coeff_valid, 1'b1);
    do_reset();
    coeff_ready = 1'b1;
    do_start();
    feed_word(mk(30'd7, QV));
    wait_size(1);
    repeat (3) @(negedge clk);
    chk("mid_done", 64'(done_cnt), 64'd0);
    exp_q = '{30'd7};
    chk_seq("mid_seq");

    for (int r = 0; r < 8; r++) random_run();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uniform_reject_sampler.md
UNIFORM_REJECT_SAMPLER -- requirements
Module: uniform_reject_sampler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- COEFF_W, 30, coefficient width in bits.
- Q, 30'd1073479681, modulus; accepted coefficients lie in [0, Q).
- N_COEFFS, 4096, coefficients produced per run.
- FIFO_DEPTH, 4, output FIFO entries (power of two).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst_n, in, 1, reset, asynchronous and active-low.
- start, in, 1, begin a run (sampled in IDLE only).
- random_in, in, 64, PRNG word.
- random_valid, in, 1, random_in is valid.
- random_ready, out, 1, word accepted this cycle when random_valid & random_ready.
- coeff_out, out, COEFF_W, FIFO head coefficient.
- coeff_valid, out, 1, FIFO non-empty.
- coeff_ready, in, 1, consumer pops the head when coeff_valid & coeff_ready.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse at end of run.
REQ-003 The chunk count SHALL be K = floor(64/COEFF_W); K = 2 at default. Bits above K*COEFF_W are discarded.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, LOAD, SPLIT, DRAIN.
REQ-005 IDLE: start=1 SHALL clear the accepted counter and chunk index, then go to LOAD next cycle; start in any other state SHALL be ignored.
REQ-006 LOAD: random_ready SHALL be 1. A handshake SHALL latch random_in into the word register and go to SPLIT; random_ready SHALL be 0 in all other states.
REQ-007 SPLIT: each cycle SHALL examine chunk = word[idx*COEFF_W +: COEFF_W], idx starting at 0 (LSB first).
REQ-008 A chunk with chunk < Q (unsigned) SHALL be pushed if the FIFO is not full at the start of the cycle, then idx advances; if the FIFO is full, idx and state SHALL hold (stall).
REQ-009 A chunk with chunk >= Q SHALL be rejected: no push, idx advances, no stall even when the FIFO is full.
REQ-010 Each push SHALL increment the accepted counter. When the counter reaches N_COEFFS, the FSM SHALL go to DRAIN immediately and discard the remaining chunks of the word.
REQ-011 After examining chunk K-1 without reaching N_COEFFS, the FSM SHALL return to LOAD with idx=0.
REQ-012 DRAIN: when the FIFO is empty, done SHALL pulse for one cycle and the FSM SHALL go to IDLE in the same transition.
REQ-013 FIFO: coeff_out and coeff_valid SHALL reflect the head combinationally from registers. A pop and push in the same cycle SHALL leave occupancy unchanged. Pointers SHALL wrap modulo FIFO_DEPTH. A pop on empty SHALL have no effect.
REQ-014 Minimum latency: from the random_valid handshake to coeff_valid=1 for an accepted chunk 0 SHALL be 2 cycles (LOAD capture, SPLIT push, visible next edge).
REQ-015 Steady-state throughput SHALL be at most 1 chunk examined per cycle, plus 1 LOAD cycle per word.

Reset
REQ-016 rst_n=0 SHALL asynchronously force: state=IDLE, counter=0, idx=0, FIFO empty, word register=0.
REQ-017 Under reset, outputs SHALL be: random_ready=0, coeff_valid=0, coeff_out=0, busy=0, done=0.
REQ-018 Reset asserted mid-run SHALL abort the run with no done pulse, and any FIFO contents SHALL be lost.
REQ-019 Operation SHALL resume on the first clk edge after rst_n deasserts.

Verification
REQ-020 Accept: start, then random_in=64'h0000_0005_0000_0003 with coeff_ready=1 -> coeff_out 3 then 20, one LOAD, no stall.
REQ-021 Reject: random_in=64'h0000_0000_3FFF_FFFF -> chunk0 0x3FFFFFFF rejected, chunk1 0 pushed, exactly one coeff emitted.
REQ-022 Backpressure: coeff_ready=0, all chunks accepted -> 4 pushes, then SPLIT stalls with random_ready=0. Raising coeff_ready resumes with no coefficient lost or duplicated.
REQ-023 Run end: N_COEFFS=3, words each yielding 2 accepts -> third push enters DRAIN, 4th chunk discarded, done pulses once after the FIFO empties, busy falls the same cycle.
REQ-024 Reset mid-SPLIT with FIFO holding 2 entries -> all outputs 0 immediately, and a new start works normally.
REQ-025 start pulsed during LOAD/SPLIT/DRAIN -> no effect on the counter or state.
